// File: rtl/activation_array.sv
`default_nettype none
// ============================================================================
// activation_array : captures LANES signed operands, applies a selectable
// activation and streams results lane by lane into a parallel result bank.
// Revision 1.0
// ============================================================================
module activation_array #(
  parameter int LANES       = 4,
  parameter int DW          = 16,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [DW-1:0]            clamp_max,
  input  logic [LANES-1:0][DW-1:0] din,
  output logic                     busy,
  output logic [LANES-1:0][DW-1:0] dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic                     out_last,
  output logic                     done
);

  localparam int            IW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [LANES-1:0][DW-1:0] lanes_q;
  logic [1:0]               mode_q;
  logic [DW-1:0]            clamp_q;
  logic [LANES-1:0][DW-1:0] dout_q;
  logic [DW-1:0]            hold_q;
  logic                     capture;
  logic                     xfer;
  logic [DW-1:0]            act_val;

  function automatic logic [DW-1:0] activate(
    input logic [1:0]           m,
    input logic signed [DW-1:0] x,
    input logic signed [DW-1:0] cmax
  );
    logic signed [DW-1:0] c;
    logic signed [DW-1:0] r;
    // A negative ceiling collapses the clamp window to exactly zero.
    c = cmax[DW-1] ? '0 : cmax;
    r = x;
    case (m)
      2'b01:   r = x[DW-1] ? '0 : x;
      2'b10:   r = x[DW-1] ? (x >>> LEAKY_SHIFT) : x;
      2'b11: begin
        if (x[DW-1])   r = '0;
        else if (x > c) r = c;
        else           r = x;
      end
      default: r = x;
    endcase
    return r;
  endfunction

  assign act_val = activate(mode_q, lanes_q[idx_q], clamp_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          xfer = 1'b1;
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lanes_q <= '0;
      mode_q  <= '0;
      clamp_q <= '0;
      dout_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        lanes_q <= din;
        mode_q  <= mode;
        clamp_q <= clamp_max;
      end
      // Keeps out_data showing the last streamed value once RUN is left.
      if (state_q == RUN) hold_q <= act_val;
      if (xfer) dout_q[idx_q] <= act_val;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == RUN);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign done      = (state_q == DONE);
  assign out_data  = out_valid ? act_val : hold_q;
  assign dout      = dout_q;

endmodule
`default_nettype wire

// File: doc/activation_array.md
ACTIVATION_ARRAY -- requirements
Module: activation_array

Interface
REQ-001 SHALL have parameter LANES, default 4: number of input lanes, >=2.
REQ-002 SHALL have parameter DW, default 16: signed two's-complement lane width.
REQ-003 SHALL have parameter LEAKY_SHIFT, default 3: arithmetic right-shift amount for leaky mode, 1..DW-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to load din and begin a pass.
REQ-007 mode  input  2  activation select: 00 bypass, 01 ReLU, 10 leaky ReLU, 11 clamped ReLU.
REQ-008 clamp_max  input  DW  signed upper bound for mode 11.
REQ-009 din  input  LANES x DW  parallel lane inputs.
REQ-010 busy  output  1  high while a pass is in progress.
REQ-011 dout  output  LANES x DW  registered parallel results.
REQ-012 out_valid  output  1  stream-data valid.
REQ-013 out_ready  input  1  stream-data accepted by consumer.
REQ-014 out_data  output  DW  stream result for the current lane.
REQ-015 out_last  output  1  marks the final lane of a pass.
REQ-016 done  output  1  single-cycle pulse at end of pass.

Function
REQ-017 SHALL implement states IDLE, RUN and DONE.
REQ-018 IDLE with start=1: capture din, mode and clamp_max into internal registers, set lane index to 0, go to RUN. busy=1 from the next cycle.
REQ-019 start SHALL be ignored in RUN and DONE; the captured operands and mode stay unchanged until the next IDLE capture.
REQ-020 RUN: out_valid=1, and out_data=f(captured lane[index]), derived only from registers.
REQ-021 Transfer occurs on a cycle with out_valid=1 and out_ready=1. On transfer, dout[index] is written with f(lane[index]), and the index increments.
REQ-022 out_last SHALL be 1 exactly when out_valid=1 and index=LANES-1. A transfer with out_last=1 moves the block to DONE.
REQ-023 While out_ready=0 in RUN, out_data, out_last and index SHALL hold stable. There is no timeout.
REQ-024 DONE SHALL last exactly one cycle, with done=1, busy=1 and out_valid=0, then go to IDLE.
REQ-025 Outside RUN, out_valid=0 and out_last=0. out_data holds its last value.
REQ-026 Latency: with start at edge T and out_ready held 1, transfers occur at T+1..T+LANES and done is high in cycle T+LANES+1. Each stalled cycle adds one cycle.
REQ-027 f for mode 00: f(x)=x.
REQ-028 f for mode 01: f(x)=0 if x<0, else x.
REQ-029 f for mode 10: f(x)=x>>>LEAKY_SHIFT (sign-extending) if x<0, else x. Negative inputs never round to 0; -1 maps to -1.
REQ-030 f for mode 11: f(x)=min(max(x,0),C), where C=clamp_max if clamp_max>=0, else C=0.
REQ-031 All comparisons SHALL be signed at width DW. No result widens or wraps.
REQ-032 dout lanes not yet transferred in a pass SHALL keep their previous values.

Reset
REQ-033 When rst=0, the block SHALL go to IDLE asynchronously. dout, out_data, the captured registers and the index clear to 0; busy, out_valid, out_last and done clear to 0.
REQ-034 Reset asserted mid-RUN SHALL abort the pass with no further transfers. After release, the block waits for a new start.

Verification
REQ-035 ReLU: LANES=4, mode=01, din={5,-3,0,32767}, out_ready=1, start at T. Required: out_data 5,0,0,32767 at T+1..T+4; out_last only at T+4; done at T+5; dout={5,0,0,32767}.
REQ-036 Leaky: mode=10, din={-8,-1,16,-32768}. Required: out_data -1,-1,16,-4096.
REQ-037 Clamp: mode=11, clamp_max=6, din={7,-2,6,3}. Required: out_data 6,0,6,3. Repeat with clamp_max=-5: required outputs all 0.
REQ-038 Backpressure: ReLU pass with out_ready=0 for 3 cycles after the first transfer. Required: out_data and out_last stable during the stall; done at T+8.
REQ-039 Start while busy: pulse start with new din and mode mid-RUN. Required: the stream is unchanged and no new pass begins.
REQ-040 Mid-pass reset: assert rst=0 at the second transfer. Required: all outputs are 0 immediately. After release, out_valid stays 0 until a new start.
